msp_seq_ctrl: RTL and testbench

Sequencer for the MEL spectrogram datapath inside the ICB slave wrapper. Sits between the command FIFO, the MEL_SPEC core and the response FIFO, and replaces the software-driven `start`/`win_coe_lut_en` strobes.
- Loads the window-coefficient LUT once.
- Streams one full window and then N_FRAMES-1 hops of samples from the command FIFO.
- Waits for each frame's MEL_BANDS mel outputs before feeding the next hop.
- Flags response-FIFO overflow.

---
 rtl/msp_ctrl_pkg.sv | 35 +++
 rtl/msp_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_msp_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/msp_ctrl_pkg.sv
// Shared state encoding and status-word layout for the MEL sequencer.
// The ICB register block builds its read-only status word with msp_status().
package msp_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WIN_LOAD = 3'd1,
      ST_FILL     = 3'd2,
      ST_HOP      = 3'd3,
      ST_WAIT_MEL = 3'd4,
      ST_DONE     = 3'd5,
      ST_ERR      = 3'd6
   } msp_state_e;

   localparam int STS_STATE_LSB     = 0;
   localparam int STS_STATE_W       = 3;
   localparam int STS_ERR_OVF_BIT   = 4;
   localparam int STS_ERR_PROTO_BIT = 5;
   localparam int STS_FRAME_LSB     = 8;
   localparam int STS_FRAME_W       = 8;

   function automatic logic [31:0] msp_status(input logic [STS_STATE_W-1:0] st,
                                              input logic                   ovf,
                                              input logic                   proto,
                                              input logic [STS_FRAME_W-1:0] fc);
      logic [31:0] w;
      w = '0;
      w[STS_STATE_LSB +: STS_STATE_W] = st;
      w[STS_ERR_OVF_BIT]              = ovf;
      w[STS_ERR_PROTO_BIT]            = proto;
      w[STS_FRAME_LSB +: STS_FRAME_W] = fc;
      return w;
   endfunction

endpackage

// File: rtl/msp_seq_ctrl.sv
// Sequences LUT load, window fill, hops and mel collection; pops are combinational from state and
// in_empty (zero latency), an empty command FIFO stalls the phase, response overflow lands in ERR.
module msp_seq_ctrl
   import msp_ctrl_pkg::*;
#(
   parameter int WIN_LEN   = 480,
   parameter int HOP_LEN   = 160,
   parameter int MEL_BANDS = 40,
   parameter int N_FRAMES  = 101
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          go,
   input  logic                          skip_win,
   input  logic                          abort,
   input  logic                          in_empty,
   input  logic                          out_full,
   input  logic                          mel_avail,
   output logic                          rd_en,
   output logic                          win_coe_lut_en,
   output logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic                          err_ovf,
   output logic                          err_proto,
   output logic [$clog2(N_FRAMES+1)-1:0] frame_cnt,
   output logic [2:0]                    state
);

   localparam int SW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam int MW = (MEL_BANDS > 1) ? $clog2(MEL_BANDS) : 1;
   localparam int FW = $clog2(N_FRAMES+1);

   localparam logic [SW-1:0] WIN_LAST   = SW'(WIN_LEN-1);
   localparam logic [SW-1:0] HOP_LAST   = SW'(HOP_LEN-1);
   localparam logic [MW-1:0] MEL_LAST   = MW'(MEL_BANDS-1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(N_FRAMES-1);

   msp_state_e    st;
   logic [SW-1:0] smp_cnt;
   logic [MW-1:0] mel_cnt;
   logic          pop_phase;
   logic          proto_hit;

   assign pop_phase      = (st == ST_WIN_LOAD) || (st == ST_FILL) || (st == ST_HOP);
   assign rd_en          = pop_phase && !in_empty;
   assign win_coe_lut_en = rd_en && (st == ST_WIN_LOAD);
   assign start          = rd_en && (st != ST_WIN_LOAD);
   assign busy           = (st != ST_IDLE) && (st != ST_DONE) && (st != ST_ERR);
   assign state          = st;
   assign proto_hit      = busy && (st != ST_WAIT_MEL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= ST_IDLE;
         smp_cnt   <= '0;
         mel_cnt   <= '0;
         frame_cnt <= '0;
         done      <= 1'b0;
         err_ovf   <= 1'b0;
         err_proto <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            st        <= ST_IDLE;
            smp_cnt   <= '0;
            mel_cnt   <= '0;
            frame_cnt <= '0;
            err_ovf   <= 1'b0;
            err_proto <= 1'b0;
         end else if (mel_avail && (out_full || proto_hit)) begin
            // a lost or unexpected mel byte corrupts the frame, so the run is dropped
            st      <= ST_ERR;
            smp_cnt <= '0;
            mel_cnt <= '0;
            if (out_full)  err_ovf   <= 1'b1;
            if (proto_hit) err_proto <= 1'b1;
         end else begin
            case (st)
               ST_IDLE, ST_DONE, ST_ERR: begin
                  if (go) begin
                     st        <= skip_win ? ST_FILL : ST_WIN_LOAD;
                     smp_cnt   <= '0;
                     mel_cnt   <= '0;
                     frame_cnt <= '0;
                     err_ovf   <= 1'b0;
                     err_proto <= 1'b0;
                  end
               end
               ST_WIN_LOAD, ST_FILL, ST_HOP: begin
                  if (rd_en) begin
                     if (smp_cnt == ((st == ST_HOP) ? HOP_LAST : WIN_LAST)) begin
                        smp_cnt <= '0;
                        st      <= (st == ST_WIN_LOAD) ? ST_FILL : ST_WAIT_MEL;
                     end else begin
                        smp_cnt <= smp_cnt + 1'b1;
                     end
                  end
               end
               ST_WAIT_MEL: begin
                  if (mel_avail) begin
                     if (mel_cnt == MEL_LAST) begin
                        mel_cnt   <= '0;
                        frame_cnt <= frame_cnt + 1'b1;
                        if (frame_cnt == FRAME_LAST) begin
                           st   <= ST_DONE;
                           done <= 1'b1;
                        end else begin
                           st <= ST_HOP;
                        end
                     end else begin
                        mel_cnt <= mel_cnt + 1'b1;
                     end
                  end
               end
               default: st <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_msp_seq_ctrl.sv
// Bench for msp_seq_ctrl: a run-level model (pop and mel totals per run) predicts every output each cycle.
module tb_msp_seq_ctrl;

   localparam int WL = 8;
   localparam int HL = 4;
   localparam int MB = 3;
   localparam int NF = 2;
   localparam int FW = $clog2(NF+1);

   localparam int MD_IDLE = 0;
   localparam int MD_RUN  = 1;
   localparam int MD_DONE = 2;
   localparam int MD_ERR  = 3;

   logic clk = 1'b0;
   logic rst_n, go, skip_win, abort, in_empty, out_full, mel_avail;
   logic rd_en, win_coe_lut_en, start, busy, done, err_ovf, err_proto;
   logic [FW-1:0] frame_cnt;
   logic [2:0] state;

   always #5 clk = ~clk;

   msp_seq_ctrl #(.WIN_LEN(WL), .HOP_LEN(HL), .MEL_BANDS(MB), .N_FRAMES(NF)) dut (
      .clk(clk), .rst_n(rst_n), .go(go), .skip_win(skip_win), .abort(abort),
      .in_empty(in_empty), .out_full(out_full), .mel_avail(mel_avail),
      .rd_en(rd_en), .win_coe_lut_en(win_coe_lut_en), .start(start), .busy(busy),
      .done(done), .err_ovf(err_ovf), .err_proto(err_proto),
      .frame_cnt(frame_cnt), .state(state)
   );

   int n_chk = 0, n_pass = 0;
   bit chk_en = 0;

   task automatic check(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   // Run-level model: the phase follows from how many pops and mel bytes the run has seen so far.
   int m_mode, m_pops, m_mels;
   bit m_skip, m_ovf, m_proto, m_done;
   int e_st;

   function automatic int exp_st(input int mode, input bit skip, input int pops, input int mels);
      int lut, fd;
      if (mode == MD_IDLE) return 0;
      if (mode == MD_DONE) return 5;
      if (mode == MD_ERR)  return 6;
      lut = skip ? 0 : WL;
      fd  = mels / MB;
      if (pops < lut) return 1;
      if (pops < lut + WL + fd*HL) return (fd == 0) ? 2 : 3;
      return 4;
   endfunction

   assign e_st = exp_st(m_mode, m_skip, m_pops, m_mels);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode <= MD_IDLE; m_pops <= 0; m_mels <= 0;
         m_skip <= 0; m_ovf <= 0; m_proto <= 0; m_done <= 0;
      end else begin
         m_done <= 0;
         if (abort) begin
            m_mode <= MD_IDLE; m_pops <= 0; m_mels <= 0; m_ovf <= 0; m_proto <= 0;
         end else if (mel_avail && (out_full || (e_st >= 1 && e_st <= 3))) begin
            m_mode <= MD_ERR;
            if (out_full) m_ovf <= 1;
            if (e_st >= 1 && e_st <= 3) m_proto <= 1;
         end else if (e_st == 0 || e_st >= 5) begin
            if (go) begin
               m_mode <= MD_RUN; m_skip <= skip_win; m_pops <= 0; m_mels <= 0;
               m_ovf <= 0; m_proto <= 0;
            end
         end else begin
            if (e_st <= 3 && !in_empty) m_pops <= m_pops + 1;
            if (e_st == 4 && mel_avail) begin
               m_mels <= m_mels + 1;
               if (m_mels + 1 == NF*MB) begin
                  m_mode <= MD_DONE;
                  m_done <= 1;
               end
            end
         end
      end
   end

   int n_rd, n_lut, n_st, n_done, n_fill;
   bit seen_pop, first_start;

   task automatic clr_tally();
      n_rd = 0; n_lut = 0; n_st = 0; n_done = 0; n_fill = 0; seen_pop = 0; first_start = 0;
   endtask

   // Per-cycle comparison of every output against the model, plus pop tallies for the scenarios.
   always @(negedge clk) begin
      logic [12:0] act_v, exp_v;
      bit e_pop;
      #2;
      if (chk_en && rst_n) begin
         e_pop = (e_st >= 1 && e_st <= 3) && !in_empty;
         exp_v = {3'(e_st), (e_st >= 1 && e_st <= 4), e_pop, e_pop && e_st == 1,
                  e_pop && e_st != 1, m_done, m_ovf, m_proto, FW'(m_mels / MB)};
         act_v = {state, busy, rd_en, win_coe_lut_en, start, done, err_ovf, err_proto, frame_cnt};
         check("cycle {state,busy,rd,lut,start,done,ovf,proto,fc}", longint'(act_v), longint'(exp_v));
         if (rd_en) begin
            if (!seen_pop) begin first_start = start; seen_pop = 1; end
            n_rd++;
         end
         if (win_coe_lut_en) n_lut++;
         if (start) n_st++;
         if (done) n_done++;
         if (state == 3'd2) n_fill++;
      end
   end

   task automatic kick(input bit skip);
      @(negedge clk); go = 1; skip_win = skip;
      @(negedge clk); go = 0; skip_win = 0;
   endtask

   task automatic advance_to(input int target, input int budget);
      int n = 0;
      while (e_st != target && n < budget) begin
         in_empty = 0; mel_avail = (e_st == 4);
         @(negedge clk); n++;
      end
      mel_avail = 0;
      check("reach_state", longint'(state), target);
   endtask

   task automatic run_done(input int budget, input int p_empty);
      int n = 0;
      while (m_mode != MD_DONE && n < budget) begin
         in_empty  = ($urandom_range(99) < p_empty);
         mel_avail = (e_st == 4) && ($urandom_range(1) == 1);
         out_full  = 0;
         @(negedge clk); n++;
      end
      in_empty = 0; mel_avail = 0;
      check("run_done_state", longint'(state), 5);
   endtask

   task automatic check_full_run(input string tag);
      check({tag, "_lut_pops"}, n_lut, WL);
      check({tag, "_start_pops"}, n_st, WL + HL);
      check({tag, "_rd_pops"}, n_rd, 2*WL + HL);
      check({tag, "_done_pulses"}, n_done, 1);
      check({tag, "_frame_cnt"}, longint'(frame_cnt), 2);
   endtask

   initial begin
      rst_n = 0; go = 0; skip_win = 0; abort = 0; in_empty = 0; out_full = 0; mel_avail = 0;
      #12;
      check("rst_state", longint'(state), 0);
      check("rst_rd_en", longint'(rd_en), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_frame_cnt", longint'(frame_cnt), 0);
      check("rst_flags", longint'({done, err_ovf, err_proto, start, win_coe_lut_en}), 0);
      @(negedge clk); rst_n = 1; chk_en = 1;

      // normal run, FIFO never empty
      clr_tally();
      kick(0);
      run_done(500, 0);
      #3;
      check_full_run("normal");

      // LUT already loaded, random FIFO gaps
      @(negedge clk); clr_tally();
      kick(1);
      run_done(800, 30);
      #3;
      check("skip_first_pop_is_start", first_start, 1);
      check("skip_lut_pops", n_lut, 0);
      check("skip_start_pops", n_st, WL + HL);
      check("skip_done_pulses", n_done, 1);

      // FILL with in_empty toggling, first FILL cycle empty
      @(negedge clk); clr_tally();
      kick(1);
      for (int i = 0; i < 16; i++) begin
         in_empty = (i % 2 == 0);
         @(negedge clk);
      end
      in_empty = 0;
      check("toggle_fill_cycles", n_fill, 16);
      check("toggle_start_pops", n_st, 8);
      check("toggle_state_wait", longint'(state), 4);
      run_done(500, 0);

      // overflow in WAIT_MEL, then go restarts
      @(negedge clk);
      kick(1);
      advance_to(4, 100);
      mel_avail = 1; out_full = 1;
      @(negedge clk); mel_avail = 0; out_full = 0;
      check("ovf_flag", longint'(err_ovf), 1);
      check("ovf_state", longint'(state), 6);
      check("ovf_busy", longint'(busy), 0);
      go = 1; skip_win = 1;
      @(negedge clk); go = 0; skip_win = 0;
      check("ovf_cleared_by_go", longint'(err_ovf), 0);
      check("ovf_restart_state", longint'(state), 2);
      abort = 1;
      @(negedge clk); abort = 0;

      // abort together with go after two HOP pops
      kick(1);
      advance_to(3, 200);
      @(negedge clk);
      @(negedge clk);
      in_empty = 1; abort = 1; go = 1;
      @(negedge clk);
      abort = 0; go = 0; in_empty = 0;
      check("abort_state", longint'(state), 0);
      check("abort_frame_cnt", longint'(frame_cnt), 0);
      clr_tally();
      repeat (5) @(negedge clk);
      check("abort_no_pops", n_rd, 0);

      // async reset in the middle of WIN_LOAD
      kick(0);
      in_empty = 0;
      repeat (3) @(negedge clk);
      #1 rst_n = 0;
      #1;
      check("areset_rd_en", longint'(rd_en), 0);
      check("areset_lut_en", longint'(win_coe_lut_en), 0);
      check("areset_state", longint'(state), 0);
      @(negedge clk); rst_n = 1;
      clr_tally();
      kick(0);
      run_done(800, 20);
      #3;
      check_full_run("after_reset");

      // random traffic including errors, aborts and restarts
      @(negedge clk);
      for (int i = 0; i < 3000; i++) begin
         go        = ($urandom_range(99) < 6);
         skip_win  = $urandom_range(1) == 1;
         abort     = ($urandom_range(99) < 2);
         in_empty  = ($urandom_range(99) < 30);
         out_full  = ($urandom_range(99) < 5);
         mel_avail = (e_st == 4) ? ($urandom_range(99) < 50) : ($urandom_range(99) < 3);
         @(negedge clk);
      end
      go = 0; abort = 0; mel_avail = 0; out_full = 0; in_empty = 0;
      @(negedge clk);
      #3;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
